// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port dmem arbiter (cpu / nic).
// The beat counter is sized for the largest legal burst cap so any MAX_BURST fits.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_OWN = 2'd1,
      NIC_OWN = 2'd2
   } owner_t;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_NIC = 1'b1
   } port_t;

   typedef struct packed {
      logic  valid;
      port_t port;
   } rd_tag_t;

   localparam int MAX_BURST_LIMIT = 255;
   localparam int BEAT_CNT_W      = $clog2(MAX_BURST_LIMIT + 1);
   localparam int DMEM_IDX_W      = 9;

   function automatic owner_t owner_of(input port_t p);
      return (p == PORT_CPU) ? CPU_OWN : NIC_OWN;
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational two-way picker: fixed CPU priority, or round-robin when rr_en,
// with force_other handing a tie to the port that did not win last.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic  cpu_req,
   input  logic  nic_req,
   input  port_t last_winner,
   input  logic  force_other,
   input  logic  rr_en,
   output port_t winner,
   output logic  any_gnt
);

   port_t not_last;

   always_comb begin
      not_last = (last_winner == PORT_CPU) ? PORT_NIC : PORT_CPU;
      any_gnt  = cpu_req | nic_req;
      winner   = PORT_CPU;
      if (cpu_req && nic_req) begin
         if (force_other || rr_en) begin
            winner = not_last;
         end
      end else if (nic_req) begin
         winner = PORT_NIC;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port dmem between the CPU and NIC ports: locked bursts with
// a beat cap, and a read tag returning data one cycle later. Round-robin via DMEM_ARB_RR_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_lock,
   input  logic              cpu_wr,
   input  logic [0:ADDR_W-1] cpu_addr,
   input  logic [0:DATA_W-1] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [0:DATA_W-1] cpu_rdata,
   input  logic              nic_req,
   input  logic              nic_lock,
   input  logic              nic_wr,
   input  logic [0:ADDR_W-1] nic_addr,
   input  logic [0:DATA_W-1] nic_wdata,
   output logic              nic_gnt,
   output logic              nic_rvalid,
   output logic [0:DATA_W-1] nic_rdata,
   output logic              memEn,
   output logic              memWrEn,
   output logic [0:ADDR_W-1] memAddr,
   output logic [0:DATA_W-1] dataOut,
   input  logic [0:DATA_W-1] dataIn
);

`ifdef DMEM_ARB_RR_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   owner_t                state_q, state_d;
   logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   port_t                 last_winner_q, last_winner_d;
   logic                  force_q, force_d;
   rd_tag_t               rd_tag_q, rd_tag_d;

   port_t                 pick_winner;
   logic                  pick_any;
   logic                  arb, gnt_any, gnt_en, new_grant, win_lock, win_wr;
   port_t                 gnt_port;
   logic [BEAT_CNT_W-1:0] cnt_cur, cnt_inc;

   dmem_arb_pick u_pick (
      .cpu_req     (cpu_req),
      .nic_req     (nic_req),
      .last_winner (last_winner_q),
      .force_other (force_q),
      .rr_en       (RR_EN),
      .winner      (pick_winner),
      .any_gnt     (pick_any)
   );

   always_comb begin
      state_d       = state_q;
      beat_cnt_d    = beat_cnt_q;
      last_winner_d = last_winner_q;
      force_d       = force_q;
      arb           = 1'b0;
      gnt_any       = 1'b0;
      gnt_port      = PORT_CPU;
      new_grant     = 1'b0;
      cnt_cur       = '0;

      // An owner that drops req falls straight through to arbitration this cycle.
      case (state_q)
         CPU_OWN: begin
            if (cpu_req) begin
               gnt_any  = 1'b1;
               gnt_port = PORT_CPU;
               cnt_cur  = beat_cnt_q;
            end else begin
               arb = 1'b1;
            end
         end
         NIC_OWN: begin
            if (nic_req) begin
               gnt_any  = 1'b1;
               gnt_port = PORT_NIC;
               cnt_cur  = beat_cnt_q;
            end else begin
               arb = 1'b1;
            end
         end
         default: arb = 1'b1;
      endcase

      if (arb) begin
         gnt_any   = pick_any;
         gnt_port  = pick_winner;
         new_grant = pick_any;
      end

      win_lock = (gnt_port == PORT_CPU) ? cpu_lock : nic_lock;
      win_wr   = (gnt_port == PORT_CPU) ? cpu_wr   : nic_wr;
      cnt_inc  = cnt_cur + 1'b1;

      if (gnt_any) begin
         if (new_grant) begin
            last_winner_d = gnt_port;
            force_d       = 1'b0;
         end
         if (win_lock && (cnt_inc < BEAT_CNT_W'(MAX_BURST))) begin
            state_d    = owner_of(gnt_port);
            beat_cnt_d = cnt_inc;
         end else begin
            // Releasing while still locked means the cap was hit: hand the next tie over.
            state_d    = IDLE;
            beat_cnt_d = '0;
            force_d    = win_lock;
         end
      end else begin
         state_d    = IDLE;
         beat_cnt_d = '0;
      end

      gnt_en         = gnt_any & reset;
      rd_tag_d.valid = gnt_en & ~win_wr;
      rd_tag_d.port  = gnt_port;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         beat_cnt_q    <= '0;
         last_winner_q <= PORT_NIC;
         force_q       <= 1'b0;
         rd_tag_q      <= '0;
      end else begin
         state_q       <= state_d;
         beat_cnt_q    <= beat_cnt_d;
         last_winner_q <= last_winner_d;
         force_q       <= force_d;
         rd_tag_q      <= rd_tag_d;
      end
   end

   always_comb begin
      cpu_gnt    = gnt_en && (gnt_port == PORT_CPU);
      nic_gnt    = gnt_en && (gnt_port == PORT_NIC);
      memEn      = gnt_en;
      memWrEn    = gnt_en & win_wr;
      memAddr    = '0;
      dataOut    = '0;
      if (gnt_en) begin
         memAddr = (gnt_port == PORT_CPU) ? cpu_addr  : nic_addr;
         dataOut = (gnt_port == PORT_CPU) ? cpu_wdata : nic_wdata;
      end
      cpu_rvalid = rd_tag_q.valid && (rd_tag_q.port == PORT_CPU);
      nic_rvalid = rd_tag_q.valid && (rd_tag_q.port == PORT_NIC);
      cpu_rdata  = rd_tag_q.valid ? dataIn : '0;
      nic_rdata  = rd_tag_q.valid ? dataIn : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port dmem behind it.
// Expectations follow the build: round-robin when DMEM_ARB_RR_EN is defined.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic              cpu_req, cpu_lock, cpu_wr;
   logic [0:ADDR_W-1] cpu_addr;
   logic [0:DATA_W-1] cpu_wdata;
   logic              cpu_gnt, cpu_rvalid;
   logic [0:DATA_W-1] cpu_rdata;
   logic              nic_req, nic_lock, nic_wr;
   logic [0:ADDR_W-1] nic_addr;
   logic [0:DATA_W-1] nic_wdata;
   logic              nic_gnt, nic_rvalid;
   logic [0:DATA_W-1] nic_rdata;
   logic              memEn, memWrEn;
   logic [0:ADDR_W-1] memAddr;
   logic [0:DATA_W-1] dataOut;
   logic [0:DATA_W-1] dataIn;

   logic [63:0] mem [0:(1<<DMEM_IDX_W)-1];

   int n_cmp = 0;
   int n_err = 0;

`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(8)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .nic_req(nic_req), .nic_lock(nic_lock), .nic_wr(nic_wr), .nic_addr(nic_addr),
      .nic_wdata(nic_wdata), .nic_gnt(nic_gnt), .nic_rvalid(nic_rvalid), .nic_rdata(nic_rdata),
      .memEn(memEn), .memWrEn(memWrEn), .memAddr(memAddr), .dataOut(dataOut), .dataIn(dataIn)
   );

   // Behavioural dmem: synchronous write, registered read, low 9 address bits decoded.
   always @(posedge clk) begin
      if (memEn && memWrEn) mem[memAddr[ADDR_W-9:ADDR_W-1]] <= dataOut;
      if (memEn && !memWrEn) dataIn <= mem[memAddr[ADDR_W-9:ADDR_W-1]];
   end

   task automatic idle_inputs();
      cpu_req = 0; cpu_lock = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
      nic_req = 0; nic_lock = 0; nic_wr = 0; nic_addr = '0; nic_wdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0;
      cpu_req = 1; nic_req = 1; cpu_addr = 32'h33; nic_wr = 1;
      #1;
      n_cmp++; if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL rst_cpu_gnt: got %0b want 0", cpu_gnt); end
      n_cmp++; if (nic_gnt !== 1'b0) begin n_err++; $display("FAIL rst_nic_gnt: got %0b want 0", nic_gnt); end
      n_cmp++; if (memEn !== 1'b0) begin n_err++; $display("FAIL rst_memEn: got %0b want 0", memEn); end
      n_cmp++; if (memWrEn !== 1'b0) begin n_err++; $display("FAIL rst_memWrEn: got %0b want 0", memWrEn); end
      n_cmp++; if (memAddr !== 32'h0) begin n_err++; $display("FAIL rst_memAddr: got %h want 0", memAddr); end
      n_cmp++; if (cpu_rvalid !== 1'b0 || nic_rvalid !== 1'b0) begin
         n_err++; $display("FAIL rst_rvalid: got %0b%0b want 00", cpu_rvalid, nic_rvalid); end
      idle_inputs();
      @(negedge clk);
      reset = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_single_read();
      do_reset();
      @(negedge clk);
      cpu_req = 1; cpu_addr = 32'h10;
      #1;
      n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL rd_cpu_gnt: got %0b want 1", cpu_gnt); end
      n_cmp++; if (memEn !== 1'b1 || memWrEn !== 1'b0) begin
         n_err++; $display("FAIL rd_mem_ctl: got en=%0b wr=%0b want en=1 wr=0", memEn, memWrEn); end
      n_cmp++; if (memAddr !== 32'h10) begin n_err++; $display("FAIL rd_memAddr: got %h want 00000010", memAddr); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_cmp++; if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_cpu_rvalid: got %0b want 1", cpu_rvalid); end
      n_cmp++; if (cpu_rdata !== 64'hC0DE0010_5A5A0010) begin
         n_err++; $display("FAIL rd_cpu_rdata: got %h want c0de00105a5a0010", cpu_rdata); end
      n_cmp++; if (nic_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_nic_rvalid: got %0b want 0", nic_rvalid); end
      n_cmp++; if (memEn !== 1'b0) begin n_err++; $display("FAIL rd_idle_memEn: got %0b want 0", memEn); end
      $display("test_single_read done");
   endtask

   task automatic test_alternate();
      logic exp_cpu;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         cpu_req = 1; nic_req = 1; cpu_addr = 32'(k); nic_addr = 32'(k + 100);
         #1;
         exp_cpu = RR ? ((k % 2) == 0) : 1'b1;
         n_cmp++; if (cpu_gnt !== exp_cpu || nic_gnt !== !exp_cpu) begin
            n_err++; $display("FAIL alt_gnt[%0d]: got cpu=%0b nic=%0b want cpu=%0b nic=%0b",
                              k, cpu_gnt, nic_gnt, exp_cpu, !exp_cpu); end
      end
      idle_inputs();
      $display("test_alternate done");
   endtask

   task automatic test_burst_cap();
      logic exp_cpu;
      do_reset();
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         cpu_req = 1; cpu_lock = 1; cpu_addr = 32'(k);
         nic_req = 1; nic_lock = 0; nic_addr = 32'(k + 200);
         #1;
         exp_cpu = (k != 9);
         n_cmp++; if (cpu_gnt !== exp_cpu || nic_gnt !== !exp_cpu) begin
            n_err++; $display("FAIL burst_gnt[beat %0d]: got cpu=%0b nic=%0b want cpu=%0b nic=%0b",
                              k, cpu_gnt, nic_gnt, exp_cpu, !exp_cpu); end
      end
      idle_inputs();
      $display("test_burst_cap done");
   endtask

   task automatic test_release();
      do_reset();
      @(negedge clk);
      nic_req = 1; nic_lock = 1; nic_addr = 32'h40;
      #1;
      n_cmp++; if (nic_gnt !== 1'b1) begin n_err++; $display("FAIL rel_nic_first: got %0b want 1", nic_gnt); end
      @(negedge clk);
      cpu_req = 1; cpu_addr = 32'h41;
      #1;
      n_cmp++; if (cpu_gnt !== 1'b0 || nic_gnt !== 1'b1) begin
         n_err++; $display("FAIL rel_blocked: got cpu=%0b nic=%0b want cpu=0 nic=1", cpu_gnt, nic_gnt); end
      @(negedge clk);
      nic_req = 0;
      #1;
      n_cmp++; if (cpu_gnt !== 1'b1 || memAddr !== 32'h41) begin
         n_err++; $display("FAIL rel_handover: got cpu_gnt=%0b addr=%h want 1 00000041", cpu_gnt, memAddr); end
      idle_inputs();
      $display("test_release done");
   endtask

   task automatic test_write_read();
      do_reset();
      @(negedge clk);
      nic_req = 1; nic_wr = 1; nic_addr = 32'h5; nic_wdata = 64'hDEADBEEF_00000001;
      #1;
      n_cmp++; if (nic_gnt !== 1'b1 || memWrEn !== 1'b1) begin
         n_err++; $display("FAIL wr_ctl: got gnt=%0b wr=%0b want 1 1", nic_gnt, memWrEn); end
      n_cmp++; if (memAddr !== 32'h5 || dataOut !== 64'hDEADBEEF_00000001) begin
         n_err++; $display("FAIL wr_bus: got addr=%h data=%h want 00000005 deadbeef00000001", memAddr, dataOut); end
      @(negedge clk);
      idle_inputs();
      cpu_req = 1; cpu_addr = 32'h5;
      #1;
      n_cmp++; if (cpu_gnt !== 1'b1 || memWrEn !== 1'b0) begin
         n_err++; $display("FAIL wr_rd_ctl: got gnt=%0b wr=%0b want 1 0", cpu_gnt, memWrEn); end
      n_cmp++; if (nic_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_no_resp: got %0b want 0", nic_rvalid); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_cmp++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 64'hDEADBEEF_00000001) begin
         n_err++; $display("FAIL wr_rd_data: got v=%0b d=%h want 1 deadbeef00000001", cpu_rvalid, cpu_rdata); end
      $display("test_write_read done");
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         cpu_req = 1; cpu_lock = 1; cpu_addr = 32'(k + 16);
      end
      #1;
      n_cmp++; if (cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b1) begin
         n_err++; $display("FAIL mid_pre: got gnt=%0b rvalid=%0b want 1 1", cpu_gnt, cpu_rvalid); end
      #1;
      reset = 1'b0;
      #1;
      n_cmp++; if (cpu_gnt !== 1'b0 || memEn !== 1'b0 || memAddr !== 32'h0) begin
         n_err++; $display("FAIL mid_async: got gnt=%0b en=%0b addr=%h want 0 0 0", cpu_gnt, memEn, memAddr); end
      n_cmp++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 64'h0) begin
         n_err++; $display("FAIL mid_rvalid: got v=%0b d=%h want 0 0", cpu_rvalid, cpu_rdata); end
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++; if (cpu_rvalid !== 1'b0 || nic_rvalid !== 1'b0) begin
         n_err++; $display("FAIL mid_post_rvalid: got cpu=%0b nic=%0b want 0 0", cpu_rvalid, nic_rvalid); end
      @(negedge clk);
      nic_req = 1; nic_addr = 32'h20;
      #1;
      n_cmp++; if (nic_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
         n_err++; $display("FAIL mid_first_gnt: got nic=%0b cpu=%0b want 1 0", nic_gnt, cpu_gnt); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_cmp++; if (nic_rvalid !== 1'b1 || nic_rdata !== 64'hC0DE0020_5A5A0020) begin
         n_err++; $display("FAIL mid_nic_rd: got v=%0b d=%h want 1 c0de00205a5a0020", nic_rvalid, nic_rdata); end
      $display("test_reset_mid_burst done");
   endtask

   initial begin
      for (int i = 0; i < (1 << DMEM_IDX_W); i++) begin
         mem[i] = {32'hC0DE0000 + 32'(i), 32'h5A5A0000 + 32'(i)};
      end
      dataIn = '0;
      reset  = 1'b1;
      idle_inputs();
      test_reset();
      test_single_read();
      test_alternate();
      test_burst_cap();
      test_release();
      test_write_read();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
